window_generator_3x3: RTL and testbench

// - Streaming producer of 3x3 pixel neighbourhoods for the convolution datapath.
// - Accepts a raster-order pixel stream (one COLOR_CHANNEL sample per beat).
// - Buffers two image lines and emits one 3x3 window per interior pixel, ready to drive

---
 rtl/window_generator_3x3.sv | 192 +++++++++++++++++++
 tb/tb_window_generator_3x3.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_generator_3x3.sv
// window_generator_3x3
// Streaming 3x3 neighbourhood generator. Takes a raster-order pixel stream,
// keeps the two previous image lines in line buffers, and emits one 3x3
// window for every interior pixel (border positions produce no window).
// Window layout: o_pixel_area[3*r+c], r=0 is the oldest row, c=0 is the
// leftmost column; index 4 is the centre, index 8 the newest pixel.
// Optional feature macro: WINDOW_COORD_EN adds o_center_x / o_center_y,
// the centre coordinate of the window currently on o_pixel_area.
module window_generator_3x3 #(
    parameter int COLOR_CHANNEL       = 8,
    parameter int IMAGE_WIDTH         = 640,
    parameter int IMAGE_HEIGHT        = 480,
    parameter int KERNEL_NUM_ELEMENTS = 9
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [COLOR_CHANNEL-1:0] i_pixel,
    input  logic                     i_pixel_valid,
    input  logic                     i_sof,
    output logic                     o_pixel_ready,
    output logic [COLOR_CHANNEL-1:0] o_pixel_area [KERNEL_NUM_ELEMENTS-1:0],
    output logic                     o_area_valid,
    input  logic                     i_area_ready,
    output logic                     o_frame_done
`ifdef WINDOW_COORD_EN
    ,
    output logic [$clog2(IMAGE_WIDTH)-1:0]  o_center_x,
    output logic [$clog2(IMAGE_HEIGHT)-1:0] o_center_y
`endif
);

    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);

    // The window datapath is hard-wired to a 3x3 neighbourhood.
    generate
        if (KERNEL_NUM_ELEMENTS != 9) begin : g_bad_kernel
            $error("window_generator_3x3: KERNEL_NUM_ELEMENTS must be 9");
        end
    endgenerate

    typedef logic [COLOR_CHANNEL-1:0] pix_t;

    // Line buffers: line1 holds row-1, line2 holds row-2 (contents never reset).
    pix_t line1_mem [IMAGE_WIDTH];
    pix_t line2_mem [IMAGE_WIDTH];

    // Window shift registers, indexed [row][col]; row 0 oldest, col 0 leftmost.
    pix_t win_q [3][3];
    pix_t win_d [3][3];

    pix_t area_q [KERNEL_NUM_ELEMENTS-1:0];
    pix_t area_d [KERNEL_NUM_ELEMENTS-1:0];

    logic [CW-1:0] col_q, col_d, col_eff;
    logic [RW-1:0] row_q, row_d, row_eff;
    logic          area_valid_q, area_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          ready_en_q, ready_en_d;

    logic          accept;
    logic          emit;
    pix_t          rd_mid;
    pix_t          rd_top;

`ifdef WINDOW_COORD_EN
    logic [CW-1:0] center_x_q, center_x_d;
    logic [RW-1:0] center_y_q, center_y_d;
`endif

    // Handshake and position of the beat being offered this cycle.
    always_comb begin
        o_pixel_ready = ready_en_q && (!area_valid_q || i_area_ready);
        accept        = i_pixel_valid && o_pixel_ready;
        // A start-of-frame beat is always pixel (0,0), regardless of counters.
        col_eff       = i_sof ? '0 : col_q;
        row_eff       = i_sof ? '0 : row_q;
        rd_mid        = line1_mem[col_eff];
        rd_top        = line2_mem[col_eff];
        emit          = accept && (col_eff >= CW'(2)) && (row_eff >= RW'(2));
    end

    // Line buffer update: read-before-write, shifting row-1 down into row-2.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            line1_mem[col_eff] <= i_pixel;
            line2_mem[col_eff] <= rd_mid;
        end
    end

    // Column/row counters with wrap at line and frame end.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_eff == COL_LAST) begin
                col_d = '0;
                row_d = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
            end else begin
                col_d = col_eff + 1'b1;
                row_d = row_eff;
            end
        end
    end

    // Window shift on every accepted beat, border positions included.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = rd_top;
            win_d[1][2] = rd_mid;
            win_d[2][2] = i_pixel;
        end
    end

    // Output stage: load a window on interior beats, hold under backpressure.
    always_comb begin
        area_d       = area_q;
        area_valid_d = area_valid_q;
        if (emit) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    area_d[3*r+c] = win_d[r][c];
                end
            end
            area_valid_d = 1'b1;
        end else if (i_area_ready) begin
            area_valid_d = 1'b0;
        end
        frame_done_d = accept && (col_eff == COL_LAST) && (row_eff == ROW_LAST);
        ready_en_d   = 1'b1;
    end

`ifdef WINDOW_COORD_EN
    // Centre coordinate travels with the window it describes.
    always_comb begin
        center_x_d = center_x_q;
        center_y_d = center_y_q;
        if (emit) begin
            center_x_d = col_eff - 1'b1;
            center_y_d = row_eff - 1'b1;
        end
    end
`endif

    // State registers with synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q        <= '0;
            row_q        <= '0;
            area_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            ready_en_q   <= 1'b0;
            win_q        <= '{default: '0};
            area_q       <= '{default: '0};
`ifdef WINDOW_COORD_EN
            center_x_q   <= '0;
            center_y_q   <= '0;
`endif
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            area_valid_q <= area_valid_d;
            frame_done_q <= frame_done_d;
            ready_en_q   <= ready_en_d;
            win_q        <= win_d;
            area_q       <= area_d;
`ifdef WINDOW_COORD_EN
            center_x_q   <= center_x_d;
            center_y_q   <= center_y_d;
`endif
        end
    end

    // Output drive.
    always_comb begin
        o_pixel_area = area_q;
        o_area_valid = area_valid_q;
        o_frame_done = frame_done_q;
`ifdef WINDOW_COORD_EN
        o_center_x   = center_x_q;
        o_center_y   = center_y_q;
`endif
    end

endmodule

// File: tb/tb_window_generator_3x3.sv
// Directed bench for window_generator_3x3 on a 5x4 image, pixel = 16*row+col.
module tb_window_generator_3x3;

    localparam int CC = 8;
    localparam int W  = 5;
    localparam int H  = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [CC-1:0] i_pixel = '0;
    logic          i_pixel_valid = 1'b0;
    logic          i_sof = 1'b0;
    logic          o_pixel_ready;
    logic [CC-1:0] o_pixel_area [8:0];
    logic          o_area_valid;
    logic          i_area_ready = 1'b1;
    logic          o_frame_done;
`ifdef WINDOW_COORD_EN
    logic [2:0]    o_center_x;
    logic [1:0]    o_center_y;
`endif

    window_generator_3x3 #(
        .COLOR_CHANNEL(CC), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .KERNEL_NUM_ELEMENTS(9)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pixel(i_pixel), .i_pixel_valid(i_pixel_valid),
        .i_sof(i_sof), .o_pixel_ready(o_pixel_ready), .o_pixel_area(o_pixel_area),
        .o_area_valid(o_area_valid), .i_area_ready(i_area_ready), .o_frame_done(o_frame_done)
`ifdef WINDOW_COORD_EN
        , .o_center_x(o_center_x), .o_center_y(o_center_y)
`endif
    );

    always #5 i_clk = ~i_clk;

    int passed = 0;
    int total  = 0;

    // Hand-computed windows for the 5x4 frame, in emission order.
    logic [7:0] exp_win [6][9];
    int         exp_cx  [6];
    int         exp_cy  [6];

    // Stream description and observations filled by run_stream.
    logic [7:0] s_px  [64];
    logic       s_sof [64];
    logic [7:0] got_win [16][9];
    int         got_cx [16];
    int         got_cy [16];
    int         n_win, n_fd, first_valid_cyc, stall_obs;
    int         acc_cyc [64];
    bit         fd_with_valid, stall_ready_seen, stall_changed, timeout;
    logic [7:0] fd_win [9];

    task automatic load_frame(input int start);
        for (int k = 0; k < W*H; k++) begin
            s_px[start+k]  = 8'((k / W) * 16 + (k % W));
            s_sof[start+k] = (k == 0);
        end
    endtask

    // Drives n beats (starting at a negedge), optional stall of the first window,
    // optional idle cycles carrying a stray i_sof; records everything observed.
    task automatic run_stream(input int n, input int stall, input bit gaps);
        int idx = 0;
        int cyc = 0;
        int tail = 0;
        int stall_left = stall;
        bit gap_pending = 0;
        bit snap_ok = 0;
        logic [7:0] snap [9];
        n_win = 0; n_fd = 0; first_valid_cyc = -1; stall_obs = 0;
        fd_with_valid = 0; stall_ready_seen = 0; stall_changed = 0; timeout = 0;
        for (int w = 0; w < 16; w++) for (int i = 0; i < 9; i++) got_win[w][i] = 8'hFF;
        while (tail < 4 && cyc < n + 60) begin
            i_area_ready = !(stall_left > 0 && o_area_valid);
            if (idx < n && !(gaps && gap_pending)) begin
                i_pixel_valid = 1'b1; i_pixel = s_px[idx]; i_sof = s_sof[idx];
            end else begin
                i_pixel_valid = 1'b0; i_pixel = 8'hEE; i_sof = gaps;
            end
            #1;
            if (o_area_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (!i_area_ready) begin
                stall_obs++; stall_left--;
                if (o_pixel_ready) stall_ready_seen = 1;
                if (!o_area_valid) stall_changed = 1;
                for (int i = 0; i < 9; i++) begin
                    if (!snap_ok) snap[i] = o_pixel_area[i];
                    else if (snap[i] !== o_pixel_area[i]) stall_changed = 1;
                end
                snap_ok = 1;
            end
            if (o_area_valid && i_area_ready && n_win < 16) begin
                for (int i = 0; i < 9; i++) got_win[n_win][i] = o_pixel_area[i];
`ifdef WINDOW_COORD_EN
                got_cx[n_win] = int'(o_center_x); got_cy[n_win] = int'(o_center_y);
`endif
                n_win++;
            end
            if (o_frame_done) begin
                n_fd++; fd_with_valid = o_area_valid;
                for (int i = 0; i < 9; i++) fd_win[i] = o_pixel_area[i];
            end
            if (i_pixel_valid && o_pixel_ready) begin
                acc_cyc[idx] = cyc; idx++; gap_pending = (idx % 4 == 0);
            end else if (!i_pixel_valid) begin
                gap_pending = 0;
            end
            if (idx >= n) tail++;
            cyc++;
            @(negedge i_clk);
        end
        if (idx < n) timeout = 1;
        i_pixel_valid = 1'b0; i_sof = 1'b0; i_area_ready = 1'b1;
    endtask

    task automatic test_reset;
        bit zero;
        i_rst = 1'b1; i_pixel_valid = 1'b0; i_area_ready = 1'b1;
        repeat (2) @(negedge i_clk);
        #1;
        total++; if (o_area_valid !== 1'b0) $display("FAIL reset_area_valid: got %b expected 0", o_area_valid); else passed++;
        total++; if (o_frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b expected 0", o_frame_done); else passed++;
        total++; if (o_pixel_ready !== 1'b0) $display("FAIL reset_ready_in_reset: got %b expected 0", o_pixel_ready); else passed++;
        zero = 1;
        for (int i = 0; i < 9; i++) if (o_pixel_area[i] !== 8'd0) zero = 0;
        total++; if (!zero) $display("FAIL reset_area_zero: got %0d at idx0 expected all 0", o_pixel_area[0]); else passed++;
        i_rst = 1'b0;
        @(negedge i_clk); #1;
        total++; if (o_pixel_ready !== 1'b1) $display("FAIL reset_ready_after: got %b expected 1", o_pixel_ready); else passed++;
        @(negedge i_clk);
    endtask

    task automatic test_basic_frame;
        bit ok; int bad;
        load_frame(0);
        run_stream(W*H, 0, 0);
        total++; if (timeout) $display("FAIL basic_timeout: got 1 expected 0"); else passed++;
        total++; if (n_win !== 6) $display("FAIL basic_count: got %0d expected 6", n_win); else passed++;
        for (int w = 0; w < 6; w++) begin
            ok = 1; bad = 0;
            for (int i = 0; i < 9; i++) if (got_win[w][i] !== exp_win[w][i]) begin ok = 0; bad = i; end
            total++;
            if (ok) passed++;
            else $display("FAIL basic_win%0d: element %0d got %0d expected %0d", w, bad, got_win[w][bad], exp_win[w][bad]);
        end
        total++; if (first_valid_cyc !== acc_cyc[12] + 1)
            $display("FAIL basic_latency: got cycle %0d expected %0d", first_valid_cyc, acc_cyc[12] + 1); else passed++;
        total++; if (n_fd !== 1) $display("FAIL frame_done_count: got %0d expected 1", n_fd); else passed++;
        total++; if (!fd_with_valid) $display("FAIL frame_done_with_valid: got 0 expected 1"); else passed++;
        ok = 1; bad = 0;
        for (int i = 0; i < 9; i++) if (fd_win[i] !== exp_win[5][i]) begin ok = 0; bad = i; end
        total++; if (!ok) $display("FAIL frame_done_window: element %0d got %0d expected %0d", bad, fd_win[bad], exp_win[5][bad]); else passed++;
`ifdef WINDOW_COORD_EN
        for (int w = 0; w < 6; w++) begin
            total++;
            if (got_cx[w] !== exp_cx[w] || got_cy[w] !== exp_cy[w])
                $display("FAIL coord%0d: got (%0d,%0d) expected (%0d,%0d)", w, got_cx[w], got_cy[w], exp_cx[w], exp_cy[w]);
            else passed++;
        end
`endif
    endtask

    task automatic test_backpressure;
        bit ok; int bad;
        load_frame(0);
        run_stream(W*H, 3, 0);
        total++; if (stall_obs !== 3) $display("FAIL bp_stall_cycles: got %0d expected 3", stall_obs); else passed++;
        total++; if (stall_ready_seen) $display("FAIL bp_ready_low: got 1 expected 0"); else passed++;
        total++; if (stall_changed) $display("FAIL bp_window_held: got changed expected stable"); else passed++;
        total++; if (n_win !== 6) $display("FAIL bp_count: got %0d expected 6", n_win); else passed++;
        for (int w = 0; w < 6; w++) begin
            ok = 1; bad = 0;
            for (int i = 0; i < 9; i++) if (got_win[w][i] !== exp_win[w][i]) begin ok = 0; bad = i; end
            total++;
            if (ok) passed++;
            else $display("FAIL bp_win%0d: element %0d got %0d expected %0d", w, bad, got_win[w][bad], exp_win[w][bad]);
        end
    endtask

    task automatic test_gaps_stray_sof;
        bit ok; int bad;
        load_frame(0);
        run_stream(W*H, 0, 1);
        total++; if (n_win !== 6) $display("FAIL gap_count: got %0d expected 6", n_win); else passed++;
        for (int w = 0; w < 6; w++) begin
            ok = 1; bad = 0;
            for (int i = 0; i < 9; i++) if (got_win[w][i] !== exp_win[w][i]) begin ok = 0; bad = i; end
            total++;
            if (ok) passed++;
            else $display("FAIL gap_win%0d: element %0d got %0d expected %0d", w, bad, got_win[w][bad], exp_win[w][bad]);
        end
    endtask

    task automatic test_sof_restart;
        bit ok; int bad;
        for (int k = 0; k < 8; k++) begin
            s_px[k] = 8'(8'hA0 + k); s_sof[k] = (k == 0);
        end
        load_frame(8);
        run_stream(8 + W*H, 0, 0);
        total++; if (n_win !== 6) $display("FAIL sof_count: got %0d expected 6", n_win); else passed++;
        total++; if (first_valid_cyc !== acc_cyc[8 + 12] + 1)
            $display("FAIL sof_first_window: got cycle %0d expected %0d", first_valid_cyc, acc_cyc[20] + 1); else passed++;
        for (int w = 0; w < 6; w++) begin
            ok = 1; bad = 0;
            for (int i = 0; i < 9; i++) if (got_win[w][i] !== exp_win[w][i]) begin ok = 0; bad = i; end
            total++;
            if (ok) passed++;
            else $display("FAIL sof_win%0d: element %0d got %0d expected %0d", w, bad, got_win[w][bad], exp_win[w][bad]);
        end
        total++; if (n_fd !== 1) $display("FAIL sof_frame_done: got %0d expected 1", n_fd); else passed++;
    endtask

    task automatic test_reset_mid_frame;
        bit ok; int bad;
        for (int k = 0; k < 13; k++) begin
            i_pixel_valid = 1'b1; i_pixel = 8'((k / W) * 16 + (k % W)); i_sof = (k == 0);
            @(negedge i_clk);
        end
        i_pixel_valid = 1'b0; i_sof = 1'b0; i_area_ready = 1'b0;
        #1;
        total++; if (o_area_valid !== 1'b1) $display("FAIL rstmid_pre_valid: got %b expected 1", o_area_valid); else passed++;
        ok = 1; bad = 0;
        for (int i = 0; i < 9; i++) if (o_pixel_area[i] !== exp_win[0][i]) begin ok = 0; bad = i; end
        total++; if (!ok) $display("FAIL rstmid_pre_window: element %0d got %0d expected %0d", bad, o_pixel_area[bad], exp_win[0][bad]); else passed++;
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        total++; if (o_area_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", o_area_valid); else passed++;
        ok = 1;
        for (int i = 0; i < 9; i++) if (o_pixel_area[i] !== 8'd0) ok = 0;
        total++; if (!ok) $display("FAIL rstmid_area_zero: got %0d at idx0 expected all 0", o_pixel_area[0]); else passed++;
        total++; if (o_pixel_ready !== 1'b0) $display("FAIL rstmid_ready_low: got %b expected 0", o_pixel_ready); else passed++;
        @(negedge i_clk); #1;
        total++; if (o_pixel_ready !== 1'b1) $display("FAIL rstmid_ready_back: got %b expected 1", o_pixel_ready); else passed++;
        i_area_ready = 1'b1;
        @(negedge i_clk);
        load_frame(0);
        run_stream(W*H, 0, 0);
        total++; if (n_win !== 6) $display("FAIL rstmid_count: got %0d expected 6", n_win); else passed++;
        for (int w = 0; w < 6; w++) begin
            ok = 1; bad = 0;
            for (int i = 0; i < 9; i++) if (got_win[w][i] !== exp_win[w][i]) begin ok = 0; bad = i; end
            total++;
            if (ok) passed++;
            else $display("FAIL rstmid_win%0d: element %0d got %0d expected %0d", w, bad, got_win[w][bad], exp_win[w][bad]);
        end
    endtask

    initial begin
        exp_win = '{
            '{8'd0,  8'd1,  8'd2,  8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34},
            '{8'd1,  8'd2,  8'd3,  8'd17, 8'd18, 8'd19, 8'd33, 8'd34, 8'd35},
            '{8'd2,  8'd3,  8'd4,  8'd18, 8'd19, 8'd20, 8'd34, 8'd35, 8'd36},
            '{8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34, 8'd48, 8'd49, 8'd50},
            '{8'd17, 8'd18, 8'd19, 8'd33, 8'd34, 8'd35, 8'd49, 8'd50, 8'd51},
            '{8'd18, 8'd19, 8'd20, 8'd34, 8'd35, 8'd36, 8'd50, 8'd51, 8'd52}
        };
        exp_cx = '{1, 2, 3, 1, 2, 3};
        exp_cy = '{1, 1, 1, 2, 2, 2};
        @(negedge i_clk);
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_gaps_stray_sof();
        test_sof_restart();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
